heap_pop: RTL
=============

Name: heap_pop

Overview:
- Extract-max engine for the pipelined max-heap; it is the reader/remover side of the heap insert pipeline.
- On a pop request it returns the root entry (largest count with its address), moves the last entry to the root, and sifts it down one level per iteration.
- It drives the heap storage read/write ports and pulses a decrement to the element-count owner.
- While a pop is in progress the insert side is held off through pop_ready.

Parameters:
CNT_SIZE, 20, width of the count field
ADDR_SIZE, 28, width of the address field
TOTAL_LEVEL, 6, heap depth; capacity NUM_ENTRY = 2**TOTAL_LEVEL-1 (localparam); indices are 1-based, 1..NUM_ENTRY

Ports:
clk  in  1  clock; single clock domain
rst  in  1  reset, asynchronous, active-high
pop_req  in  1  pop request; accepted when pop_req && pop_ready
pop_ready  out  1  high only in IDLE
heap_count_i  in  TOTAL_LEVEL  current entry count; sampled only at accept
out_valid  out  1  one-cycle pulse; result valid
out_empty  out  1  qualifies out_valid: pop was issued on an empty heap
out_cnt  out  CNT_SIZE  popped count; held until next result
out_addr  out  ADDR_SIZE  popped address; held until next result
dec_o  out  1  one-cycle pulse; count owner decrements by 1
rd_en  out  1  storage read strobe
rd_idx_a  out  TOTAL_LEVEL  read index A
rd_idx_b  out  TOTAL_LEVEL  read index B
rd_cnt_a, rd_addr_a  in  CNT_SIZE, ADDR_SIZE  read data for A; valid the cycle after rd_en
rd_cnt_b, rd_addr_b  in  CNT_SIZE, ADDR_SIZE  read data for B; valid the cycle after rd_en
wr_en  out  1  storage write strobe; at most one write per cycle
wr_idx  out  TOTAL_LEVEL  write index
wr_cnt, wr_addr  out  CNT_SIZE, ADDR_SIZE  write data

Behaviour:
- Reset (rst high, async): state IDLE. All outputs 0 except pop_ready=1. Internal registers cleared. A pop in progress is abandoned with no further writes.
- States: IDLE, FETCH, ROOT, SIFT_RD, SIFT_CMP, EMPTY.
- Accept at cycle T in IDLE:
  - heap_count_i==0: go to EMPTY. At T+1: out_valid=1, out_empty=1, out_cnt=0, out_addr=0, no dec_o, no storage access. Back to IDLE at T+2.
  - heap_count_i>0: latch n=heap_count_i and go to FETCH.
- FETCH (T+1): rd_en=1, rd_idx_a=1, rd_idx_b=n.
- ROOT (T+2): read data valid. Register out_cnt/out_addr from A. Set item={rd_cnt_b, rd_addr_b}, m=n-1, cur=1.
- T+3: out_valid=1, out_empty=0, dec_o=1. If n==1, go to IDLE (pop_ready=1 at T+3); otherwise go to SIFT_RD.
- SIFT_RD: left=2*cur, computed TOTAL_LEVEL+1 bits wide so it cannot overflow.
  - left>m: wr_en, wr_idx=cur, write item, go to IDLE.
  - Otherwise: rd_en, rd_idx_a=left, rd_idx_b=left+1, go to SIFT_CMP.
- SIFT_CMP: right child is eligible only if left+1<=m. Pick c = right if eligible and rd_cnt_b > rd_cnt_a, else left (ties go left).
  - child.cnt > item.cnt (strict, unsigned): write child to cur, cur=c, go to SIFT_RD.
  - Otherwise: write item to cur, go to IDLE.
- Bounds: at most TOTAL_LEVEL-1 SIFT iterations. Worst-case busy time is 3+2*(TOTAL_LEVEL-1)+1 cycles.
- pop_req while busy is ignored and not queued. heap_count_i is not re-sampled mid-pop.
- Count-field ties never swap, so equal counts stay in place.
- The vacated slot n is never written. The count owner's decrement makes it invalid.

Test Plan:
- Empty pop: heap_count_i=0, pop_req at T -> out_valid=1 at T+1 with out_empty=1, cnt/addr 0; no rd_en, wr_en or dec_o.
- Single entry: n=1, idx1={cnt 7, addr 0x10} -> out_valid at T+3 with cnt 7, addr 0x10, dec_o=1; no wr_en; pop_ready=1 at T+3.
- Three entries: idx1..3 counts 50/40/30 -> out_cnt 50 at T+3; wr idx1=40 at T+4; wr idx2=30 at T+5; IDLE at T+6.
- Right child larger: n=4, counts 90/20/60/10 -> pop 90; wr idx1=60, then idx3=10; idx2 untouched.
- Tie handling: n=4, counts 9/5/5/5 -> child tie picks left but 5 is not greater than 5, so only wr idx1=5 (last entry). Repeated pops return strictly non-increasing counts, checked against a reference model while filling 63 entries and draining to empty.
- Reset mid-sift: assert rst during SIFT_CMP -> outputs 0 immediately, pop_ready=1, no wr_en after release; a following pop is handled normally.

Source files
------------

// File: rtl/heap_pop.sv
// Extract-max engine for the pipelined max-heap: returns the root entry, moves the
// last entry to the root and sifts it down one level per read/compare iteration.
module heap_pop #(
  parameter int unsigned CNT_SIZE    = 20,
  parameter int unsigned ADDR_SIZE   = 28,
  parameter int unsigned TOTAL_LEVEL = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pop_req,
  output logic                   pop_ready,
  input  logic [TOTAL_LEVEL-1:0] heap_count_i,
  output logic                   out_valid,
  output logic                   out_empty,
  output logic [CNT_SIZE-1:0]    out_cnt,
  output logic [ADDR_SIZE-1:0]   out_addr,
  output logic                   dec_o,
  output logic                   rd_en,
  output logic [TOTAL_LEVEL-1:0] rd_idx_a,
  output logic [TOTAL_LEVEL-1:0] rd_idx_b,
  input  logic [CNT_SIZE-1:0]    rd_cnt_a,
  input  logic [ADDR_SIZE-1:0]   rd_addr_a,
  input  logic [CNT_SIZE-1:0]    rd_cnt_b,
  input  logic [ADDR_SIZE-1:0]   rd_addr_b,
  output logic                   wr_en,
  output logic [TOTAL_LEVEL-1:0] wr_idx,
  output logic [CNT_SIZE-1:0]    wr_cnt,
  output logic [ADDR_SIZE-1:0]   wr_addr
);

  localparam logic [TOTAL_LEVEL-1:0] RootIdx = TOTAL_LEVEL'(1);
  localparam logic [TOTAL_LEVEL:0]   ExtOne  = (TOTAL_LEVEL + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRoot,
    StSiftRd,
    StSiftCmp,
    StEmpty
  } state_e;

  state_e state_q, state_d;

  logic [TOTAL_LEVEL-1:0] n_q, n_d;
  logic [TOTAL_LEVEL-1:0] m_q, m_d;
  logic [TOTAL_LEVEL-1:0] cur_q, cur_d;
  logic [CNT_SIZE-1:0]    item_cnt_q, item_cnt_d;
  logic [ADDR_SIZE-1:0]   item_addr_q, item_addr_d;
  logic [CNT_SIZE-1:0]    out_cnt_q, out_cnt_d;
  logic [ADDR_SIZE-1:0]   out_addr_q, out_addr_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_empty_q, out_empty_d;
  logic                   dec_q, dec_d;

  // Child indices carry one extra bit so 2*cur never wraps on the last level.
  logic [TOTAL_LEVEL:0]   left_idx;
  logic [TOTAL_LEVEL:0]   right_idx;
  logic [TOTAL_LEVEL:0]   m_ext;
  logic                   right_ok;
  logic                   pick_right;
  logic [CNT_SIZE-1:0]    child_cnt;
  logic [ADDR_SIZE-1:0]   child_addr;
  logic [TOTAL_LEVEL-1:0] child_idx;

  assign left_idx  = {cur_q, 1'b0};
  assign right_idx = left_idx + ExtOne;
  assign m_ext     = {1'b0, m_q};

  // Ties between siblings resolve to the left child.
  assign right_ok   = (right_idx <= m_ext);
  assign pick_right = right_ok && (rd_cnt_b > rd_cnt_a);
  assign child_cnt  = pick_right ? rd_cnt_b : rd_cnt_a;
  assign child_addr = pick_right ? rd_addr_b : rd_addr_a;
  assign child_idx  = pick_right ? right_idx[TOTAL_LEVEL-1:0] : left_idx[TOTAL_LEVEL-1:0];

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    m_d         = m_q;
    cur_d       = cur_q;
    item_cnt_d  = item_cnt_q;
    item_addr_d = item_addr_q;
    out_cnt_d   = out_cnt_q;
    out_addr_d  = out_addr_q;
    out_empty_d = out_empty_q;
    out_valid_d = 1'b0;
    dec_d       = 1'b0;
    rd_en       = 1'b0;
    rd_idx_a    = '0;
    rd_idx_b    = '0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_cnt      = '0;
    wr_addr     = '0;

    unique case (state_q)
      StIdle: begin
        if (pop_req) begin
          if (heap_count_i == '0) begin
            state_d     = StEmpty;
            out_valid_d = 1'b1;
            out_empty_d = 1'b1;
            out_cnt_d   = '0;
            out_addr_d  = '0;
          end else begin
            n_d     = heap_count_i;
            state_d = StFetch;
          end
        end
      end

      StFetch: begin
        rd_en    = 1'b1;
        rd_idx_a = RootIdx;
        rd_idx_b = n_q;
        state_d  = StRoot;
      end

      StRoot: begin
        out_cnt_d   = rd_cnt_a;
        out_addr_d  = rd_addr_a;
        out_empty_d = 1'b0;
        out_valid_d = 1'b1;
        dec_d       = 1'b1;
        item_cnt_d  = rd_cnt_b;
        item_addr_d = rd_addr_b;
        m_d         = n_q - RootIdx;
        cur_d       = RootIdx;
        state_d     = (n_q == RootIdx) ? StIdle : StSiftRd;
      end

      StSiftRd: begin
        if (left_idx > m_ext) begin
          // cur is a leaf of the shrunken heap: the moved item settles here.
          wr_en   = 1'b1;
          wr_idx  = cur_q;
          wr_cnt  = item_cnt_q;
          wr_addr = item_addr_q;
          state_d = StIdle;
        end else begin
          rd_en    = 1'b1;
          rd_idx_a = left_idx[TOTAL_LEVEL-1:0];
          rd_idx_b = right_idx[TOTAL_LEVEL-1:0];
          state_d  = StSiftCmp;
        end
      end

      StSiftCmp: begin
        wr_en  = 1'b1;
        wr_idx = cur_q;
        if (child_cnt > item_cnt_q) begin
          wr_cnt  = child_cnt;
          wr_addr = child_addr;
          cur_d   = child_idx;
          state_d = StSiftRd;
        end else begin
          wr_cnt  = item_cnt_q;
          wr_addr = item_addr_q;
          state_d = StIdle;
        end
      end

      StEmpty: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      n_q         <= '0;
      m_q         <= '0;
      cur_q       <= '0;
      item_cnt_q  <= '0;
      item_addr_q <= '0;
      out_cnt_q   <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_empty_q <= 1'b0;
      dec_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      m_q         <= m_d;
      cur_q       <= cur_d;
      item_cnt_q  <= item_cnt_d;
      item_addr_q <= item_addr_d;
      out_cnt_q   <= out_cnt_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_empty_q <= out_empty_d;
      dec_q       <= dec_d;
    end
  end

  assign pop_ready = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_empty = out_empty_q;
  assign out_cnt   = out_cnt_q;
  assign out_addr  = out_addr_q;
  assign dec_o     = dec_q;

endmodule
